// File: rtl/apu_pkg.sv
// ---------------------------------------------------------------------------
// apu_pkg
// Shared definitions for the APU sound channels (triangle, pulse, noise).
//   ADDR_*      : 2-bit channel register offsets within a 4-byte register bank
//   LEN_TABLE   : 32-entry length-counter load table, indexed by wr_data[7:3]
//   tri_level() : maps a 5-bit triangle step to its 4-bit output level
// ---------------------------------------------------------------------------
package apu_pkg;

    // Register offsets inside a channel's 4-byte bank ($4008..$400B for triangle)
    localparam logic [1:0] ADDR_REG0 = 2'd0;
    localparam logic [1:0] ADDR_REG1 = 2'd1;
    localparam logic [1:0] ADDR_REG2 = 2'd2;
    localparam logic [1:0] ADDR_REG3 = 2'd3;

    // NES length-counter load values
    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    // First half of the 32-step cycle ramps down (15-step), second half ramps
    // up (step-16); both reduce to inverting or passing the low nibble.
    function automatic logic [3:0] tri_level(input logic [4:0] step);
        return step[4] ? step[3:0] : ~step[3:0];
    endfunction

endpackage

// File: rtl/apu_length_counter.sv
// ---------------------------------------------------------------------------
// apu_length_counter
// Channel length counter shared by the triangle, pulse and noise channels.
//   clk_i          : system clock
//   rst_i          : asynchronous active-high reset, clears the count
//   enable_i       : channel enable level; low forces the count to zero
//   load_i         : one-clk load strobe (write to the channel's length register)
//   load_index_i   : LEN_TABLE index for the load
//   halt_i         : halt flag; freezes the count on half-frame strobes
//   half_frame_i   : frame-sequencer half strobe
//   length_o       : current count
//   active_o       : high when the count is non-zero
// ---------------------------------------------------------------------------
module apu_length_counter
    import apu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       load_i,
    input  logic [4:0] load_index_i,
    input  logic       halt_i,
    input  logic       half_frame_i,
    output logic [7:0] length_o,
    output logic       active_o
);

    logic [7:0] length_q;
    logic [7:0] length_d;

    // Priority: disable beats load, and a load in the same clk as a half-frame
    // strobe wins outright so the freshly loaded value is not decremented.
    always_comb begin
        length_d = length_q;
        if (!enable_i) begin
            length_d = 8'd0;
        end else if (load_i) begin
            length_d = LEN_TABLE[load_index_i];
        end else if (half_frame_i && !halt_i && (length_q != 8'd0)) begin
            length_d = length_q - 8'd1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            length_q <= 8'd0;
        end else begin
            length_q <= length_d;
        end
    end

    assign length_o = length_q;
    assign active_o = (length_q != 8'd0);

endmodule

// File: rtl/apu_triangle.sv
// ---------------------------------------------------------------------------
// apu_triangle
// NES APU triangle channel: period timer, 32-step sequencer, linear counter
// and length counter, with a registered 4-bit output level.
//   clk, rst        : system clock, asynchronous active-high reset
//   cpu_ce          : CPU-cycle enable, clocks the period timer
//   wr_en/addr/data : register writes ($4008, $4009 ignored, $400A, $400B)
//   enable          : $4015 bit 2 channel enable level
//   quarter_frame   : clocks the linear counter
//   half_frame      : clocks the length counter
//   out_sample      : triangle level to the mixer
//   length_active   : length counter non-zero ($4015 status)
// Build option: APU_TRIANGLE_ULTRASONIC_MUTE_EN -- when defined, periods below
// 2 drive out_sample to a constant mid-level 7 while the step keeps running.
// TIMER_W must be at least 11 so that $400B can write period bits [10:8].
// ---------------------------------------------------------------------------
module apu_triangle
    import apu_pkg::*;
#(
    parameter int TIMER_W = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_ce,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       enable,
    input  logic       quarter_frame,
    input  logic       half_frame,
    output logic [3:0] out_sample,
    output logic       length_active
);

    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [4:0]         step_q, step_d;
    logic [6:0]         linear_q, linear_d;
    logic [6:0]         reload_val_q, reload_val_d;
    logic               control_q, control_d;
    logic               reload_flag_q, reload_flag_d;
    logic [3:0]         out_q, out_d;

    logic               wr_reg0;
    logic               wr_reg2;
    logic               wr_reg3;
    logic [7:0]         length;

    assign wr_reg0 = wr_en && (wr_addr == ADDR_REG0);
    assign wr_reg2 = wr_en && (wr_addr == ADDR_REG2);
    assign wr_reg3 = wr_en && (wr_addr == ADDR_REG3);

    // Length counter; the triangle's control flag doubles as the length halt.
    apu_length_counter u_length (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .load_i       (wr_reg3),
        .load_index_i (wr_data[7:3]),
        .halt_i       (control_q),
        .half_frame_i (half_frame),
        .length_o     (length),
        .active_o     (length_active)
    );

    // Next-state logic. Every decision reads only registered state, so a
    // register write and a strobe in the same clk each see pre-write values;
    // in particular a quarter-frame uses the old reload flag and the $400B
    // write's flag set survives the end-of-quarter clear.
    always_comb begin
        period_d      = period_q;
        timer_d       = timer_q;
        step_d        = step_q;
        linear_d      = linear_q;
        reload_val_d  = reload_val_q;
        control_d     = control_q;
        reload_flag_d = reload_flag_q;

        if (wr_reg0) begin
            control_d    = wr_data[7];
            reload_val_d = wr_data[6:0];
        end
        if (wr_reg2) begin
            period_d[7:0] = wr_data;
        end
        if (wr_reg3) begin
            period_d[10:8] = wr_data[2:0];
        end

        if (cpu_ce) begin
            if (timer_q == '0) begin
                timer_d = period_q;
                if ((linear_q != 7'd0) && (length != 8'd0)) begin
                    step_d = step_q + 5'd1;
                end
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end

        if (quarter_frame) begin
            if (reload_flag_q) begin
                linear_d = reload_val_q;
            end else if (linear_q != 7'd0) begin
                linear_d = linear_q - 7'd1;
            end
            if (!control_q) begin
                reload_flag_d = 1'b0;
            end
        end
        if (wr_reg3) begin
            reload_flag_d = 1'b1;
        end
    end

    // Output level follows the step with one clk of latency; a silenced
    // channel simply stops stepping so the level holds rather than dropping.
    always_comb begin
`ifdef APU_TRIANGLE_ULTRASONIC_MUTE_EN
        out_d = (period_q < TIMER_W'(2)) ? 4'd7 : tri_level(step_q);
`else
        out_d = tri_level(step_q);
`endif
    end

    // State registers; the output resets to the step-0 level of 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q      <= '0;
            timer_q       <= '0;
            step_q        <= 5'd0;
            linear_q      <= 7'd0;
            reload_val_q  <= 7'd0;
            control_q     <= 1'b0;
            reload_flag_q <= 1'b0;
            out_q         <= 4'hF;
        end else begin
            period_q      <= period_d;
            timer_q       <= timer_d;
            step_q        <= step_d;
            linear_q      <= linear_d;
            reload_val_q  <= reload_val_d;
            control_q     <= control_d;
            reload_flag_q <= reload_flag_d;
            out_q         <= out_d;
        end
    end

    assign out_sample = out_q;

endmodule

// File: doc/apu_triangle.md
APU_TRIANGLE -- requirements
Module: apu_triangle

Interface
REQ-001 Parameter: TIMER_W, default 11, width of the timer period and down-counter.
REQ-002 Port: clk  in  1  system clock; all state changes on posedge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: cpu_ce  in  1  CPU-cycle enable; the timer advances only when high.
REQ-005 Port: wr_en  in  1  register write strobe, one clk wide.
REQ-006 Port: wr_addr  in  2  0=$4008, 1=$4009 (ignored), 2=$400A, 3=$400B.
REQ-007 Port: wr_data  in  8  write data.
REQ-008 Port: enable  in  1  $4015 bit 2, channel enable level.
REQ-009 Port: quarter_frame  in  1  frame-sequencer quarter strobe, one clk wide.
REQ-010 Port: half_frame  in  1  frame-sequencer half strobe, one clk wide.
REQ-011 Port: out_sample  out  4  triangle level, feeds the mixer triangle input.
REQ-012 Port: length_active  out  1  high when length counter is non-zero ($4015 status read).

Function
REQ-013 $4008 write: control/halt flag = wr_data[7]; linear reload value = wr_data[6:0].
REQ-014 $400A write: period[7:0] = wr_data.
REQ-015 $400B write: period[10:8] = wr_data[2:0]; reload_flag set; if enable high, length = LEN_TABLE[wr_data[7:3]]. Timer and step are not disturbed.
REQ-016 Timer, on cpu_ce: if timer==0, timer = period and step advances when linear!=0 and length!=0; otherwise timer decrements.
REQ-017 Step: 5-bit, wraps 31->0; the level equals 15-step for step<16 and step-16 otherwise.
REQ-018 out_sample is registered: it reflects step one clk after the step changes.
REQ-019 When linear or length is zero, step holds and out_sample holds its last value (no forced zero).
REQ-020 Linear counter (7-bit), on quarter_frame:
  - if reload_flag, linear = reload value;
  - else, if linear!=0, decrement;
  - then, if control flag is clear, reload_flag clears.
REQ-021 Length counter (8-bit), on half_frame: decrement when halt is clear and length!=0; saturates at 0.
REQ-022 enable low forces length = 0 on every clk; $400B length loads are ignored while enable is low.
REQ-023 $400B write and half_frame in the same clk: the load wins and no decrement occurs.
REQ-024 $400B write and quarter_frame in the same clk: the quarter_frame uses the pre-write reload_flag; the new flag applies at the next quarter_frame.
REQ-025 Strobes act independently of cpu_ce; a timer underflow, quarter_frame and half_frame in the same clk are all processed.
REQ-026 length_active = (length != 0), combinational from the register.

Reset
REQ-027 rst clears to zero: period, timer, step, linear, length, reload_flag and control flag.
REQ-028 During reset, out_sample = 4'hF (step 0) and length_active = 0.
REQ-029 Reset mid-sequence aborts immediately; the first cpu_ce after release reloads the timer from period = 0.

Configuration
REQ-030 Macro APU_TRIANGLE_ULTRASONIC_MUTE_EN. When defined, out_sample = 4'd7 whenever period < 2, while step keeps running internally.
REQ-031 Without APU_TRIANGLE_ULTRASONIC_MUTE_EN, period < 2 sequences normally per REQ-016/017.

Structure
REQ-032 Package apu_pkg holds LEN_TABLE (32 x 8-bit NES length values) and the register-address constants, shared with the pulse and noise channels.
REQ-033 Sub-module apu_length_counter (load/halt/enable/half_frame logic) is instantiated here and is reusable by the other channels.

Verification
REQ-034 Step walk: enable=1; write $4008=0x81, $400A=0x00, $400B=0x08; give one quarter_frame; then hold cpu_ce=1. Required: out_sample sequences 15,14,..,0,0,1,..,15 with one step per cpu_ce.
REQ-035 Linear expiry: control=0, reload=3; write $400B; give 4 quarter_frames. Required: linear = 3,2,1,0; step then freezes and out_sample holds its value.
REQ-036 Length: enable=1; write $400B with wr_data[7:3]=1 (LEN 254), halt=0. Required: length_active=1; after 254 half_frames, length_active=0.
REQ-037 Enable drop: with length non-zero, drive enable=0. Required: length_active=0 next clk; a subsequent $400B write leaves length at 0.
REQ-038 Collision: $400B write with half_frame in the same clk, index 3 (LEN 2). Required: length = 2, not 1.
REQ-039 Macro: with APU_TRIANGLE_ULTRASONIC_MUTE_EN defined and period=1, out_sample stays 7; with the macro undefined, out_sample toggles through the sequence.
